spi_sram_target: RTL and testbench



---
 rtl/spi_sram_target.sv | 176 +++++++++++++++++
 tb/tb_spi_sram_target.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_target.sv
// SPI mode-0 serial SRAM responder (READ 0x03 / WRITE 0x02), oversampled in clk.
// Optional: define SPI_TARGET_ID_EN to answer 0x9F with ID bytes 0x0D 0x5D 0x00...
module spi_sram_target #(
    parameter int ADDR_BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_in,
    input  logic cs_in,
    input  logic mosi_in,
    output logic miso_out,
    output logic miso_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_READ,
        S_WRITE,
        S_ID,
        S_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [1:0] sclk_s, cs_s, mosi_s;
    logic       sclk_d;
    logic       rise, fall, cs_hi, mosi_b;

    logic [4:0]           bit_cnt;
    logic [7:0]           rx_sr, tx_sr, rx_byte;
    logic [ADDR_BITS-1:0] addr, addr_in;
    logic                 is_rd;
    logic                 byte_end, addr_end, mem_we;
`ifdef SPI_TARGET_ID_EN
    logic                 id_cnt;
`endif

    logic [7:0] mem [2**ADDR_BITS];

    assign rise     = sclk_s[1] & ~sclk_d;
    assign fall     = ~sclk_s[1] & sclk_d;
    assign cs_hi    = cs_s[1];
    assign mosi_b   = mosi_s[1];
    assign rx_byte  = {rx_sr[6:0], mosi_b};
    assign addr_in  = {addr[ADDR_BITS-2:0], mosi_b};
    assign byte_end = rise && (bit_cnt == 5'd7);
    assign addr_end = rise && (bit_cnt == 5'd23);
    assign mem_we   = !cs_hi && (state == S_WRITE) && byte_end;

    always_comb begin
        state_nxt = state;
        if (cs_hi) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: state_nxt = S_CMD;
                S_CMD: begin
                    if (byte_end) begin
                        unique case (1'b1)
                            (rx_byte == 8'h03),
                            (rx_byte == 8'h02): state_nxt = S_ADDR;
`ifdef SPI_TARGET_ID_EN
                            (rx_byte == 8'h9F): state_nxt = S_ID;
`endif
                            default: state_nxt = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (addr_end)
                        state_nxt = is_rd ? S_READ : S_WRITE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sclk_s <= 2'b00;
            cs_s   <= 2'b11;
            mosi_s <= 2'b00;
            sclk_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            sclk_s <= {sclk_s[0], sclk_in};
            cs_s   <= {cs_s[0], cs_in};
            mosi_s <= {mosi_s[0], mosi_in};
            sclk_d <= sclk_s[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            addr     <= '0;
            is_rd    <= 1'b0;
            miso_out <= 1'b0;
            miso_oe  <= 1'b0;
`ifdef SPI_TARGET_ID_EN
            id_cnt   <= 1'b0;
`endif
        end else if (cs_hi || state == S_IDLE) begin
            bit_cnt  <= '0;
            miso_out <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            if (rise) begin
                rx_sr   <= rx_byte;
                bit_cnt <= bit_cnt + 1'b1;
                unique case (state)
                    S_CMD: begin
                        if (byte_end) begin
                            bit_cnt <= '0;
                            is_rd   <= (rx_byte == 8'h03);
`ifdef SPI_TARGET_ID_EN
                            tx_sr   <= 8'h0D;
                            id_cnt  <= 1'b0;
`endif
                        end
                    end
                    S_ADDR: begin
                        addr <= addr_in;
                        if (addr_end) begin
                            bit_cnt <= '0;
                            if (is_rd) begin
                                tx_sr <= mem[addr_in];
                                addr  <= addr_in + 1'b1;
                            end
                        end
                    end
                    S_READ: begin
                        if (byte_end) begin
                            bit_cnt <= '0;
                            tx_sr   <= mem[addr];
                            addr    <= addr + 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (byte_end) begin
                            bit_cnt <= '0;
                            addr    <= addr + 1'b1;
                        end
                    end
`ifdef SPI_TARGET_ID_EN
                    S_ID: begin
                        if (byte_end) begin
                            bit_cnt <= '0;
                            tx_sr   <= id_cnt ? 8'h00 : 8'h5D;
                            id_cnt  <= 1'b1;
                        end
                    end
`endif
                    default: bit_cnt <= '0;
                endcase
            end
            // Data leaves on the falling edge so it is settled for the initiator's next rise
            if (fall && (state == S_READ || state == S_ID)) begin
                miso_out <= tx_sr[7];
                tx_sr    <= {tx_sr[6:0], 1'b0};
                miso_oe  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= rx_byte;
    end

endmodule

// File: tb/tb_spi_sram_target.sv
// Scoreboard bench for spi_sram_target: stimulus queues expected MISO bytes,
// a monitor assembles bytes on SCLK rises while miso_oe is high and compares.
module tb_spi_sram_target;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk_in = 1'b0;
    logic cs_in = 1'b1;
    logic mosi_in = 1'b0;
    logic miso_out;
    logic miso_oe;

    int errors = 0;
    int checks = 0;
    int oe_hi = 0;
    int bad_out = 0;
    logic [7:0] exp_q [$];

    spi_sram_target #(.ADDR_BITS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk_in  (sclk_in),
        .cs_in    (cs_in),
        .mosi_in  (mosi_in),
        .miso_out (miso_out),
        .miso_oe  (miso_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (miso_oe) oe_hi <= oe_hi + 1;
        if (rst_n && !miso_oe && miso_out) bad_out <= bad_out + 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    initial begin : monitor
        logic [7:0] mbyte;
        int mcnt;
        logic [7:0] e;
        mcnt = 0;
        mbyte = 8'h00;
        forever begin
            @(posedge sclk_in or posedge cs_in or negedge rst_n);
            if (!rst_n || cs_in) begin
                mcnt = 0;
            end else if (miso_oe) begin
                mbyte = {mbyte[6:0], miso_out};
                mcnt++;
                if (mcnt == 8) begin
                    mcnt = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none", mbyte);
                    end else begin
                        e = exp_q.pop_front();
                        check("miso_byte", mbyte, e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        mosi_in = b;
        tick(8);
        sclk_in = 1'b1;
        tick(8);
        sclk_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic start(input logic [7:0] cmd, input logic [23:0] a);
        cs_in = 1'b0;
        tick(8);
        send_byte(cmd);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic stop();
        tick(8);
        cs_in = 1'b1;
        tick(8);
    endtask

    task automatic do_write(input logic [23:0] a, input int n,
                            input logic [7:0] d0, input logic [7:0] d1);
        start(8'h02, a);
        send_byte(d0);
        if (n > 1) send_byte(d1);
        stop();
    endtask

    task automatic do_read(input logic [23:0] a, input int n,
                           input logic [7:0] e0, input logic [7:0] e1);
        exp_q.push_back(e0);
        if (n > 1) exp_q.push_back(e1);
        start(8'h03, a);
        for (int i = 0; i < n; i++) send_byte(8'h00);
        stop();
    endtask

    initial begin
        int snap;
        tick(4);
        check("reset_miso_out", {7'd0, miso_out}, 8'h00);
        check("reset_miso_oe", {7'd0, miso_oe}, 8'h00);
        rst_n = 1'b1;
        tick(8);

        // reset in the middle of a read
        do_write(24'h000000, 1, 8'h5A, 8'h00);
        start(8'h03, 24'h000000);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        tick(4);
        rst_n = 1'b0;
        #1;
        check("midread_rst_miso_out", {7'd0, miso_out}, 8'h00);
        check("midread_rst_miso_oe", {7'd0, miso_oe}, 8'h00);
        cs_in = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(8);
        do_read(24'h000000, 1, 8'h5A, 8'h00);

        // write then read
        do_write(24'h000010, 2, 8'hA5, 8'h3C);
        do_read(24'h000010, 2, 8'hA5, 8'h3C);

        // wrap
        do_write(24'h0000FF, 2, 8'h11, 8'h22);
        do_read(24'h000000, 1, 8'h22, 8'h00);
        do_read(24'h0000FF, 2, 8'h11, 8'h22);

        // upper address bits ignored
        do_write(24'hFFFF05, 1, 8'h77, 8'h00);
        do_read(24'h000005, 1, 8'h77, 8'h00);

        // aborted write leaves memory untouched
        do_write(24'h000020, 1, 8'h4B, 8'h00);
        start(8'h02, 24'h000020);
        for (int i = 7; i >= 3; i--) begin
            logic [7:0] v;
            v = 8'h99;
            send_bit(v[i]);
        end
        stop();
        do_read(24'h000020, 1, 8'h4B, 8'h00);

        // unknown command
        snap = oe_hi;
        cs_in = 1'b0;
        tick(8);
        send_byte(8'h55);
        for (int i = 0; i < 3; i++) send_byte(8'hFF);
        stop();
        checks++;
        if (oe_hi != snap) begin
            errors++;
            $display("FAIL unknown_cmd_oe: got %0d cycles high expected 0", oe_hi - snap);
        end

        // read ID
`ifdef SPI_TARGET_ID_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h5D);
        exp_q.push_back(8'h00);
        cs_in = 1'b0;
        tick(8);
        send_byte(8'h9F);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        stop();
`else
        snap = oe_hi;
        cs_in = 1'b0;
        tick(8);
        send_byte(8'h9F);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        stop();
        checks++;
        if (oe_hi != snap) begin
            errors++;
            $display("FAIL id_disabled_oe: got %0d cycles high expected 0", oe_hi - snap);
        end
`endif

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_bytes: got %0d left expected 0", exp_q.size());
        end
        checks++;
        if (bad_out != 0) begin
            errors++;
            $display("FAIL miso_out_undriven: got %0d cycles high expected 0", bad_out);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
